// File: rtl/xor_arb_pkg.sv
// xor_arb_pkg: shared state encoding and helpers for the XOR engine arbiter
package xor_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int FLAT_W = 256;
  localparam int OP_W = 32;
  function automatic int idw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic [OP_W-1:0] op_slice(input logic [FLAT_W-1:0] flat, input int idx, input int w);
    logic [FLAT_W-1:0] s;
    s = flat >> (idx * w);
    return s[OP_W-1:0] & ((OP_W'(1) << w) - OP_W'(1));
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter import xor_arb_pkg::*; #(
  parameter int NREQ = 2,
  localparam int IDW = idw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);
  // scan from the far end so the nearest request after ptr wins last
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NREQ]) begin
        idx = IDW'((int'(ptr) + i) % NREQ);
        any = 1'b1;
      end
    end
    gnt = any ? NREQ'(1) << idx : '0;
  end
endmodule

// File: rtl/xor_engine_arbiter.sv
// xor_engine_arbiter: round-robin shared bit-serial XOR/parity engine
module xor_engine_arbiter import xor_arb_pkg::*; #(
  parameter int NREQ = 2,
  parameter int DATA_W = 8,
  localparam int IDW = idw(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_W-1:0] a_flat,
  input  logic [NREQ*DATA_W-1:0] b_flat,
  output logic [NREQ-1:0]        gnt,
  output logic                   busy,
  output logic                   done,
  output logic [IDW-1:0]         done_id,
  output logic [DATA_W-1:0]      result,
  output logic                   parity
);
  localparam int CW = $clog2(DATA_W + 1);
  state_t state;
  logic [IDW-1:0] ptr, sel, arb_idx, nxt;
  logic [NREQ-1:0] arb_gnt;
  logic arb_any, bx, par;
  logic [DATA_W-1:0] a_sh, b_sh, acc;
  logic [CW-1:0] cnt;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req(req),
    .ptr(ptr),
    .gnt(arb_gnt),
    .idx(arb_idx),
    .any(arb_any)
  );
  assign bx = a_sh[0] ^ b_sh[0];
  assign nxt = (int'(sel) == NREQ - 1) ? '0 : sel + 1'b1;
  // job FSM: arbitrate in IDLE, shift one bit per RUN cycle, publish in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      sel <= '0;
      gnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      done_id <= '0;
      result <= '0;
      parity <= 1'b0;
      a_sh <= '0;
      b_sh <= '0;
      acc <= '0;
      par <= 1'b0;
      cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (arb_any) begin
          sel <= arb_idx;
          gnt <= arb_gnt;
          busy <= 1'b1;
          a_sh <= DATA_W'(op_slice(FLAT_W'(a_flat), int'(arb_idx), DATA_W));
          b_sh <= DATA_W'(op_slice(FLAT_W'(b_flat), int'(arb_idx), DATA_W));
          acc <= '0;
          par <= 1'b0;
          cnt <= '0;
          state <= RUN;
        end
        RUN: if (!req[sel]) begin
          gnt <= '0;
          busy <= 1'b0;
          ptr <= nxt;
          state <= IDLE;
        end else begin
          acc <= {bx, acc[DATA_W-1:1]};
          par <= par ^ bx;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DATA_W - 1)) state <= DONE;
        end
        DONE: begin
          done <= 1'b1;
          result <= acc;
          parity <= par;
          done_id <= sel;
          gnt <= '0;
          busy <= 1'b0;
          ptr <= nxt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xor_engine_arbiter.sv
// tb_xor_engine_arbiter: directed scenario checks for the shared XOR engine
module tb_xor_engine_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req = '0;
  logic [7:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
  logic [15:0] a_flat, b_flat;
  logic [1:0] gnt;
  logic busy, done, done_id, parity;
  logic [7:0] result;
  int n_chk = 0;
  int n_fail = 0;
  assign a_flat = {a1, a0};
  assign b_flat = {b1, b0};
  always #5 clk = ~clk;
  xor_engine_arbiter #(.NREQ(2), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .result(result), .parity(parity)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask
  task automatic wait_done(input int maxc, output int cyc, output bit ok);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!done && cyc < maxc);
    ok = done;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    req = '0;
    tick();
    n_chk++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    n_chk++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
    n_chk++; if (result !== 8'h00 || parity !== 1'b0 || done_id !== 1'b0) begin n_fail++; $display("FAIL reset_outputs: got %h/%b/%b want 00/0/0", result, parity, done_id); end
    rst_n = 1'b1;
  endtask
  task automatic test_single();
    int c;
    bit ok;
    do_reset();
    a0 = 8'hA5; b0 = 8'h0F; req = 2'b01;
    tick();
    n_chk++; if (gnt !== 2'b01 || busy !== 1'b1) begin n_fail++; $display("FAIL single_grant: got gnt=%b busy=%b want 01/1", gnt, busy); end
    wait_done(20, c, ok);
    req = 2'b00;
    n_chk++; if (!ok || c != 9) begin n_fail++; $display("FAIL single_latency: got %0d cycles done=%b want 9", c, ok); end
    n_chk++; if (result !== 8'hAA || parity !== 1'b0 || done_id !== 1'b0) begin n_fail++; $display("FAIL single_result: got %h/%b/%b want aa/0/0", result, parity, done_id); end
    n_chk++; if (gnt !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL single_release: got gnt=%b busy=%b want 00/0", gnt, busy); end
    tick();
    n_chk++; if (done !== 1'b0 || result !== 8'hAA) begin n_fail++; $display("FAIL single_hold: got done=%b result=%h want 0/aa", done, result); end
  endtask
  task automatic test_contention();
    int c;
    bit ok;
    logic [1:0] exp;
    rst_n = 1'b0;
    tick();
    a0 = 8'hA5; b0 = 8'h0F; a1 = 8'h01; b1 = 8'h00; req = 2'b11; rst_n = 1'b1;
    tick();
    n_chk++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL cont_first_grant: got %b want 01", gnt); end
    wait_done(20, c, ok);
    n_chk++; if (!ok || done_id !== 1'b0 || result !== 8'hAA) begin n_fail++; $display("FAIL cont_first_done: got ok=%b id=%b res=%h want 1/0/aa", ok, done_id, result); end
    tick();
    n_chk++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL cont_second_grant: got %b want 10", gnt); end
    wait_done(20, c, ok);
    n_chk++; if (!ok || c != 9 || done_id !== 1'b1 || result !== 8'h01 || parity !== 1'b1) begin n_fail++; $display("FAIL cont_second_done: got ok=%b c=%0d id=%b res=%h par=%b want 1/9/1/01/1", ok, c, done_id, result, parity); end
    tick();
    exp = 2'b01;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (gnt !== exp) begin n_fail++; $display("FAIL cont_rotation_%0d: got %b want %b", i, gnt, exp); end
      exp = ~exp;
      repeat (10) tick();
    end
    req = 2'b00;
    repeat (12) tick();
  endtask
  task automatic test_operand_stability();
    int c;
    bit ok;
    do_reset();
    a0 = 8'hA5; b0 = 8'h0F; req = 2'b01;
    tick();
    tick();
    tick();
    a0 = 8'hFF;
    wait_done(20, c, ok);
    req = 2'b00;
    n_chk++; if (!ok || result !== 8'hAA || parity !== 1'b0) begin n_fail++; $display("FAIL operand_stability: got ok=%b res=%h par=%b want 1/aa/0", ok, result, parity); end
  endtask
  task automatic test_abort();
    int c;
    bit ok;
    bit seen;
    do_reset();
    a1 = 8'h3C; b1 = 8'h00; req = 2'b10;
    tick();
    wait_done(20, c, ok);
    n_chk++; if (!ok || result !== 8'h3C || done_id !== 1'b1) begin n_fail++; $display("FAIL abort_prior_job: got ok=%b res=%h id=%b want 1/3c/1", ok, result, done_id); end
    a0 = 8'hA5; b0 = 8'h0F; a1 = 8'h55; req = 2'b11;
    tick();
    n_chk++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL abort_grant0: got %b want 01", gnt); end
    seen = 1'b0;
    repeat (3) begin tick(); seen |= done; end
    req = 2'b10;
    tick();
    seen |= done;
    n_chk++; if (gnt !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_release: got gnt=%b busy=%b want 00/0", gnt, busy); end
    tick();
    seen |= done;
    n_chk++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL abort_next_grant: got %b want 10", gnt); end
    n_chk++; if (seen || result !== 8'h3C) begin n_fail++; $display("FAIL abort_no_done: got done_seen=%b res=%h want 0/3c", seen, result); end
    wait_done(20, c, ok);
    req = 2'b00;
    n_chk++; if (!ok || done_id !== 1'b1 || result !== 8'h55 || parity !== 1'b0) begin n_fail++; $display("FAIL abort_after: got ok=%b id=%b res=%h par=%b want 1/1/55/0", ok, done_id, result, parity); end
  endtask
  task automatic test_reset_mid_job();
    int c;
    bit ok;
    do_reset();
    a0 = 8'hA5; b0 = 8'h0F; req = 2'b01;
    tick();
    wait_done(20, c, ok);
    tick();
    n_chk++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL midrst_regrant: got %b want 01", gnt); end
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    n_chk++; if (gnt !== 2'b00 || busy !== 1'b0 || done !== 1'b0 || result !== 8'h00 || parity !== 1'b0) begin n_fail++; $display("FAIL midrst_async: got gnt=%b busy=%b done=%b res=%h par=%b want 00/0/0/00/0", gnt, busy, done, result, parity); end
    tick();
    rst_n = 1'b1;
    tick();
    n_chk++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL midrst_fresh_grant: got %b want 01", gnt); end
    wait_done(20, c, ok);
    req = 2'b00;
    n_chk++; if (!ok || c != 9 || result !== 8'hAA || done_id !== 1'b0) begin n_fail++; $display("FAIL midrst_fresh_done: got ok=%b c=%0d res=%h id=%b want 1/9/aa/0", ok, c, result, done_id); end
  endtask
  task automatic test_parity_sweep();
    int c;
    bit ok;
    do_reset();
    a0 = 8'hFF; b0 = 8'h00; req = 2'b01;
    tick();
    wait_done(20, c, ok);
    req = 2'b00;
    n_chk++; if (!ok || result !== 8'hFF || parity !== 1'b0) begin n_fail++; $display("FAIL sweep_ff: got ok=%b res=%h par=%b want 1/ff/0", ok, result, parity); end
    a0 = 8'h80; req = 2'b01;
    tick();
    wait_done(20, c, ok);
    req = 2'b00;
    n_chk++; if (!ok || result !== 8'h80 || parity !== 1'b1 || done_id !== 1'b0) begin n_fail++; $display("FAIL sweep_80: got ok=%b res=%h par=%b id=%b want 1/80/1/0", ok, result, parity, done_id); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_contention();
    test_operand_stability();
    test_abort();
    test_reset_mid_job();
    test_parity_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
